// File: rtl/main_memory_responder_if.sv
// Cache-refill / preload bus between the instruction cache (master) and main memory (slave).
interface main_memory_responder_if;
  logic        REQ;
  logic [31:0] REQ_ADDR;
  logic        LD_EN;
  logic [31:0] LD_ADDR;
  logic [31:0] LD_DATA;
  logic        Access_MM;
  logic [31:0] Data_MM;
  logic        Valid_MM;
  logic        ERR_MM;
  logic [19:0] CNT_REQ;

  modport master (
    output REQ, REQ_ADDR, LD_EN, LD_ADDR, LD_DATA,
    input  Access_MM, Data_MM, Valid_MM, ERR_MM, CNT_REQ
  );

  modport slave (
    input  REQ, REQ_ADDR, LD_EN, LD_ADDR, LD_DATA,
    output Access_MM, Data_MM, Valid_MM, ERR_MM, CNT_REQ
  );
endinterface

// File: rtl/main_memory_responder.sv
// One-word refill responder with fixed LATENCY and a preloadable word store.
// Optional MM_RANGE_CHK_EN: out-of-range requests return zero with ERR_MM, out-of-range preloads dropped.
module main_memory_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input logic                  CLK,
  input logic                  RESET,
  main_memory_responder_if.slave mm
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  logic [31:0]       mem_q [2**ADDR_W];
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wait_q;
  logic              access_q, valid_q;
  logic [31:0]       data_q;
  logic [19:0]       cnt_q;

  logic [ADDR_W-1:0] req_idx, ld_idx;
  logic              ld_we;
  logic [31:0]       rd_word;

  assign req_idx = mm.REQ_ADDR[ADDR_W+1:2];
  assign ld_idx  = mm.LD_ADDR[ADDR_W+1:2];

  logic unused_lo;
  assign unused_lo = ^{mm.REQ_ADDR[1:0], mm.LD_ADDR[1:0]};

`ifdef MM_RANGE_CHK_EN
  logic req_oor, ld_oor, oor_q, err_q;
  assign req_oor   = |mm.REQ_ADDR[31:ADDR_W+2];
  assign ld_oor    = |mm.LD_ADDR[31:ADDR_W+2];
  assign ld_we     = mm.LD_EN & ~ld_oor;
  assign rd_word   = oor_q ? 32'd0 : mem_q[addr_q];
  assign mm.ERR_MM = err_q;

  // ERR_MM rides alongside the Valid_MM strobe of a flagged request
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && mm.REQ) oor_q <= req_oor;
      err_q <= (state_q == WAIT && wait_q == 8'd0) ? oor_q : 1'b0;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^{mm.REQ_ADDR[31:ADDR_W+2], mm.LD_ADDR[31:ADDR_W+2]};
  assign ld_we     = mm.LD_EN;
  assign rd_word   = mem_q[addr_q];
  assign mm.ERR_MM = 1'b0;
`endif

  // Store is not reset; a same-edge write is invisible to the RESP read
  always_ff @(posedge CLK) begin
    if (ld_we) mem_q[ld_idx] <= mm.LD_DATA;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wait_q   <= '0;
      access_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (mm.REQ) begin
          addr_q   <= req_idx;
          wait_q   <= LAT_M1;
          access_q <= 1'b1;
          if (cnt_q != 20'hFFFFF) cnt_q <= cnt_q + 20'd1;
          state_q  <= WAIT;
        end
        // wait_q==0 marks the edge that lands LATENCY edges after acceptance
        WAIT: if (wait_q == 8'd0) begin
          data_q  <= rd_word;
          valid_q <= 1'b1;
          state_q <= RESP;
        end else begin
          wait_q <= wait_q - 8'd1;
        end
        RESP: begin
          valid_q  <= 1'b0;
          access_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mm.Access_MM = access_q;
  assign mm.Valid_MM  = valid_q;
  assign mm.Data_MM   = data_q;
  assign mm.CNT_REQ   = cnt_q;
endmodule
